// File: rtl/nap_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nap_timer_pkg
//  Description : Shared types, digit layout constants and BCD time helpers
//                for the HH:MM:SS countdown / stopwatch core.
//  Revision    : 1.0 - initial release
// ============================================================================
package nap_timer_pkg;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // Counting direction as seen on the mode input
    typedef enum logic {
        MODE_DOWN = 1'b0,
        MODE_UP   = 1'b1
    } count_mode_e;

    // Packed time word: {h10,h1,m10,m1,s10,s1}, h10 in the MSBs
    localparam int TIME_W = 24;

    // Digit positions inside the packed time word (nibble index)
    localparam int S1  = 0;
    localparam int S10 = 1;
    localparam int M1  = 2;
    localparam int M10 = 3;
    localparam int H1  = 4;
    localparam int H10 = 5;

    // Largest legal value of a units digit and of a minutes/seconds tens digit
    localparam bcd_t DIGIT_MAX_UNITS = 4'd9;
    localparam bcd_t DIGIT_MAX_TENS  = 4'd5;

    // Largest legal value for the digit at position idx
    function automatic bcd_t digit_max(input int idx);
        return ((idx == S10) || (idx == M10)) ? DIGIT_MAX_TENS : DIGIT_MAX_UNITS;
    endfunction

    // Hours field as a plain integer
    function automatic int bcd_hours(input logic [TIME_W-1:0] t);
        return (10 * int'(t[H10*4 +: 4])) + int'(t[H1*4 +: 4]);
    endfunction

    function automatic logic bcd_time_is_zero(input logic [TIME_W-1:0] t);
        return (t == '0);
    endfunction

    // Every digit in range; in up mode the hours must also sit below the wrap
    function automatic logic bcd_time_valid(input logic [TIME_W-1:0] t,
                                            input logic              up,
                                            input int                hour_limit);
        logic ok;
        ok = 1'b1;
        for (int i = S1; i <= H10; i++) begin
            if (t[i*4 +: 4] > digit_max(i)) begin
                ok = 1'b0;
            end
        end
        if (up && (bcd_hours(t) >= hour_limit)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Ripple-borrow decrement; caller guarantees a non-zero input
    function automatic logic [TIME_W-1:0] bcd_time_dec(input logic [TIME_W-1:0] t);
        logic [TIME_W-1:0] r;
        logic              borrow;
        bcd_t              d;
        r      = t;
        borrow = 1'b1;
        for (int i = S1; i <= H10; i++) begin
            d = t[i*4 +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = digit_max(i);
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

    // Ripple-carry increment; the hour field wraps to 00 after hour_limit-1
    // (an out-of-range hour value, reachable only by a down-mode load followed
    // by a switch to up mode, also wraps rather than growing past 99)
    function automatic logic [TIME_W-1:0] bcd_time_inc(input logic [TIME_W-1:0] t,
                                                       input int                hour_limit);
        logic [TIME_W-1:0] r;
        logic              carry;
        bcd_t              d;
        r     = t;
        carry = 1'b1;
        for (int i = S1; i <= M10; i++) begin
            d = t[i*4 +: 4];
            if (carry) begin
                if (d >= digit_max(i)) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[i*4 +: 4] = d;
        end
        if (carry) begin
            if ((bcd_hours(t) >= (hour_limit - 1)) || (bcd_hours(t) >= 99)) begin
                r[H1*4 +: 8] = 8'd0;
            end else if (t[H1*4 +: 4] >= DIGIT_MAX_UNITS) begin
                r[H1*4 +: 4]  = 4'd0;
                r[H10*4 +: 4] = t[H10*4 +: 4] + 4'd1;
            end else begin
                r[H1*4 +: 4] = t[H1*4 +: 4] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Single-clock one-second enable generator. Counts
//                0..TICK_DIV-1 while enabled and flags the terminal count
//                combinationally so the consumer applies it at that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == C_TERM);
    assign tick   = en & w_term;

    // Free-run while enabled, hold when paused, restart on clear or terminal
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nap_countdown_core.sv
`default_nettype none
// ============================================================================
//  Module      : nap_countdown_core
//  Description : Six-digit BCD HH:MM:SS timer. Counts down (nap timer) or up
//                (stopwatch/clock) on a one-second enable, with pause, load
//                validation, optional auto-reload and up-mode hour wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module nap_countdown_core
    import nap_timer_pkg::*;
#(
    parameter int TICK_DIV    = 1000000,
    parameter int HOUR_LIMIT  = 24,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] set_time,
    input  logic              run,
    input  logic              mode,
    output logic [TIME_W-1:0] time_out,
    output logic              tick,
    output logic              running,
    output logic              done,
    output logic              done_pulse,
    output logic              set_err
);

    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] r_reload;
    logic              r_done;
    logic              r_tick;
    logic              r_running;
    logic              r_done_pulse;
    logic              r_set_err;

    logic [TIME_W-1:0] w_time_nxt;
    logic [TIME_W-1:0] w_reload_nxt;
    logic              w_done_nxt;
    logic              w_tick_nxt;
    logic              w_done_pulse_nxt;
    logic              w_set_err_nxt;

    logic              w_sec_tick;
    logic              w_count_en;
    count_mode_e       w_mode;
    logic              w_load_ok;
    logic [TIME_W-1:0] w_dec;
    logic [TIME_W-1:0] w_inc;
    logic              w_reload_ok;
    logic              w_expire;

    assign w_mode     = count_mode_e'(mode);
    assign w_count_en = run & ~r_done;

    // A pending load restarts the second, so its tick is discarded below
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .en    (w_count_en),
        .clr   (load),
        .tick  (w_sec_tick)
    );

    assign w_load_ok   = bcd_time_valid(set_time, (w_mode == MODE_UP), HOUR_LIMIT);
    assign w_dec       = bcd_time_dec(r_time);
    assign w_inc       = bcd_time_inc(r_time, HOUR_LIMIT);
    // A zero reload copy would just re-expire, so it falls back to stopping
    assign w_reload_ok = AUTO_RELOAD && !bcd_time_is_zero(r_reload);
    // Expiry on reaching zero, or on a tick while already sitting at zero
    assign w_expire    = bcd_time_is_zero(r_time) || bcd_time_is_zero(w_dec);

    // Next-state selection: load beats tick; reset is handled in the register
    always_comb begin
        w_time_nxt       = r_time;
        w_reload_nxt     = r_reload;
        w_done_nxt       = r_done;
        w_tick_nxt       = 1'b0;
        w_done_pulse_nxt = 1'b0;
        w_set_err_nxt    = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                w_time_nxt   = set_time;
                w_reload_nxt = set_time;
                w_done_nxt   = 1'b0;
            end else begin
                w_set_err_nxt = 1'b1;
            end
        end else if (w_sec_tick) begin
            w_tick_nxt = 1'b1;
            if (w_mode == MODE_DOWN) begin
                if (w_expire) begin
                    w_done_pulse_nxt = 1'b1;
                    if (w_reload_ok) begin
                        w_time_nxt = r_reload;
                    end else begin
                        w_time_nxt = '0;
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_time_nxt = w_dec;
                end
            end else begin
                // Incrementing only yields zero when the hour field wraps
                w_time_nxt       = w_inc;
                w_done_pulse_nxt = bcd_time_is_zero(w_inc);
            end
        end
    end

    // State and output registers, all updated at the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_time       <= '0;
            r_reload     <= '0;
            r_done       <= 1'b0;
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
            r_done_pulse <= 1'b0;
            r_set_err    <= 1'b0;
        end else begin
            r_time       <= w_time_nxt;
            r_reload     <= w_reload_nxt;
            r_done       <= w_done_nxt;
            r_tick       <= w_tick_nxt;
            r_running    <= run & ~w_done_nxt;
            r_done_pulse <= w_done_pulse_nxt;
            r_set_err    <= w_set_err_nxt;
        end
    end

    assign time_out   = r_time;
    assign tick       = r_tick;
    assign running    = r_running;
    assign done       = r_done;
    assign done_pulse = r_done_pulse;
    assign set_err    = r_set_err;

endmodule
`default_nettype wire

// File: tb/tb_nap_countdown_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nap_countdown_core
//  Description : Bench for nap_countdown_core. Two instances (plain and
//                auto-reload) share all inputs; a seconds-based reference
//                model tracks both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nap_countdown_core;

    localparam int TD = 4;
    localparam int HL = 24;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b0;
    logic        run   = 1'b0;
    logic        mode  = 1'b0;
    logic [23:0] set_time = '0;

    logic [23:0] t0, t1;
    logic        tk0, tk1, rn0, rn1, dn0, dn1, dp0, dp1, er0, er1;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = plain, 1 = auto-reload
    int m_secs[2];
    int m_rel[2];
    int m_pre[2];
    bit m_done[2];
    bit m_tick[2];
    bit m_dp[2];
    bit m_err[2];
    bit m_run[2];

    always #5 clock = ~clock;

    nap_countdown_core #(.TICK_DIV(TD), .HOUR_LIMIT(HL), .AUTO_RELOAD(1'b0)) dut0 (
        .clock(clock), .reset(reset), .load(load), .set_time(set_time), .run(run), .mode(mode),
        .time_out(t0), .tick(tk0), .running(rn0), .done(dn0), .done_pulse(dp0), .set_err(er0));

    nap_countdown_core #(.TICK_DIV(TD), .HOUR_LIMIT(HL), .AUTO_RELOAD(1'b1)) dut1 (
        .clock(clock), .reset(reset), .load(load), .set_time(set_time), .run(run), .mode(mode),
        .time_out(t1), .tick(tk1), .running(rn1), .done(dn1), .done_pulse(dp1), .set_err(er1));

    function automatic logic [23:0] sec2bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int bcd2sec(input logic [23:0] b);
        int h, m, x;
        h = int'(b[23:20]) * 10 + int'(b[19:16]);
        m = int'(b[15:12]) * 10 + int'(b[11:8]);
        x = int'(b[7:4]) * 10 + int'(b[3:0]);
        return h * 3600 + m * 60 + x;
    endfunction

    function automatic bit load_ok(input logic [23:0] b, input logic up);
        int h;
        h = int'(b[23:20]) * 10 + int'(b[19:16]);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd5) && (b[11:8] <= 4'd9) &&
               (b[15:12] <= 4'd5) && (b[19:16] <= 4'd9) && (b[23:20] <= 4'd9) &&
               (!up || (h < HL));
    endfunction

    // Advance the model by one clock edge using the current input values
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit ticked;
            if (reset) begin
                m_secs[k] = 0; m_rel[k] = 0; m_pre[k] = 0; m_done[k] = 0;
                m_tick[k] = 0; m_dp[k] = 0; m_err[k] = 0; m_run[k] = 0;
            end else begin
                ticked = run && !m_done[k] && (m_pre[k] == TD - 1) && !load;
                if (load) m_pre[k] = 0;
                else if (run && !m_done[k]) m_pre[k] = (m_pre[k] + 1) % TD;
                m_tick[k] = 0; m_dp[k] = 0; m_err[k] = 0;
                if (load) begin
                    if (load_ok(set_time, mode)) begin
                        m_secs[k] = bcd2sec(set_time);
                        m_rel[k]  = m_secs[k];
                        m_done[k] = 0;
                    end else begin
                        m_err[k] = 1;
                    end
                end else if (ticked) begin
                    m_tick[k] = 1;
                    if (!mode) begin
                        if (m_secs[k] > 0) m_secs[k] = m_secs[k] - 1;
                        if (m_secs[k] == 0) begin
                            m_dp[k] = 1;
                            if (k == 1 && m_rel[k] != 0) m_secs[k] = m_rel[k];
                            else m_done[k] = 1;
                        end
                    end else begin
                        m_secs[k] = m_secs[k] + 1;
                        if (m_secs[k] == HL * 3600) begin
                            m_secs[k] = 0;
                            m_dp[k]   = 1;
                        end
                    end
                end
                m_run[k] = run && !m_done[k];
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_load(input logic [23:0] v, input logic md);
        load = 1'b1; set_time = v; mode = md;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if ({t0, tk0, rn0, dn0, dp0, er0} !== 29'd0) begin
            errors++; $display("FAIL reset_dut0 got %h want 0", {t0, tk0, rn0, dn0, dp0, er0});
        end
        checks++;
        if ({t1, tk1, rn1, dn1, dp1, er1} !== 29'd0) begin
            errors++; $display("FAIL reset_dut1 got %h want 0", {t1, tk1, rn1, dn1, dp1, er1});
        end
        reset = 1'b0;
    endtask

    task automatic test_countdown();
        logic [23:0] exp_t;
        run = 1'b1;
        do_load(24'h000003, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            repeat (3) step();
            checks++;
            if (tk0 !== 1'b0) begin
                errors++; $display("FAIL early_tick_%0d got %b want 0", i, tk0);
            end
            step();
            exp_t = 24'(3 - i);
            checks++;
            if ({t0, tk0} !== {exp_t, 1'b1}) begin
                errors++; $display("FAIL down_tick_%0d got %h/%b want %h/1", i, t0, tk0, exp_t);
            end
        end
        checks++;
        if ({dn0, dp0, rn0} !== 3'b110) begin
            errors++; $display("FAIL expire_flags got done=%b pulse=%b running=%b want 1 1 0", dn0, dp0, rn0);
        end
        step();
        checks++;
        if ({dn0, dp0, t0} !== {2'b10, 24'h000000}) begin
            errors++; $display("FAIL expire_hold got done=%b pulse=%b t=%h want 1 0 000000", dn0, dp0, t0);
        end
        repeat (8) step();
        checks++;
        if ({t0, tk0, dn0} !== {24'h000000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL halted got t=%h tick=%b done=%b want 000000 0 1", t0, tk0, dn0);
        end
    endtask

    task automatic test_borrow();
        do_load(24'h010000, 1'b0);
        repeat (4) step();
        checks++;
        if (t0 !== 24'h005959) begin
            errors++; $display("FAIL borrow_hour got %h want 005959", t0);
        end
        do_load(24'h100000, 1'b0);
        repeat (4) step();
        checks++;
        if (t0 !== 24'h095959) begin
            errors++; $display("FAIL borrow_h10 got %h want 095959", t0);
        end
    endtask

    task automatic test_up_wrap();
        do_load(24'h235959, 1'b1);
        repeat (4) step();
        checks++;
        if ({t0, dp0, dn0} !== {24'h000000, 2'b10}) begin
            errors++; $display("FAIL up_wrap got t=%h pulse=%b done=%b want 000000 1 0", t0, dp0, dn0);
        end
        repeat (4) step();
        checks++;
        if ({t0, dp0} !== {24'h000001, 1'b0}) begin
            errors++; $display("FAIL up_after_wrap got t=%h pulse=%b want 000001 0", t0, dp0);
        end
    endtask

    task automatic test_validation();
        run = 1'b0;
        do_load(24'h006000, 1'b0);
        checks++;
        if ({er0, t0} !== {1'b1, 24'h000001}) begin
            errors++; $display("FAIL bad_minutes got err=%b t=%h want 1 000001", er0, t0);
        end
        step();
        checks++;
        if (er0 !== 1'b0) begin
            errors++; $display("FAIL err_one_cycle got %b want 0", er0);
        end
        do_load(24'h240000, 1'b1);
        checks++;
        if ({er0, t0} !== {1'b1, 24'h000001}) begin
            errors++; $display("FAIL up_hour_limit got err=%b t=%h want 1 000001", er0, t0);
        end
        do_load(24'h240000, 1'b0);
        checks++;
        if ({er0, t0} !== {1'b0, 24'h240000}) begin
            errors++; $display("FAIL down_24h got err=%b t=%h want 0 240000", er0, t0);
        end
    endtask

    task automatic test_pause();
        run = 1'b1;
        do_load(24'h000010, 1'b0);
        step(); step();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (tk0 !== 1'b0) begin
                errors++; $display("FAIL paused_tick_%0d got %b want 0", i, tk0);
            end
        end
        run = 1'b1;
        step();
        checks++;
        if (tk0 !== 1'b0) begin
            errors++; $display("FAIL resume_early got %b want 0", tk0);
        end
        step();
        checks++;
        if ({tk0, t0} !== {1'b1, 24'h000009}) begin
            errors++; $display("FAIL resume_tick got %b/%h want 1/000009", tk0, t0);
        end
        repeat (3) step();
        do_load(24'h000030, 1'b0);
        checks++;
        if ({tk0, t0} !== {1'b0, 24'h000030}) begin
            errors++; $display("FAIL load_vs_tick got %b/%h want 0/000030", tk0, t0);
        end
        repeat (4) step();
        checks++;
        if (t0 !== 24'h000029) begin
            errors++; $display("FAIL after_load_tick got %h want 000029", t0);
        end
    endtask

    task automatic test_auto_reload();
        run = 1'b1;
        do_load(24'h000002, 1'b0);
        repeat (4) step();
        checks++;
        if ({t1, dp1} !== {24'h000001, 1'b0}) begin
            errors++; $display("FAIL reload_first got %h/%b want 000001/0", t1, dp1);
        end
        repeat (4) step();
        checks++;
        if ({t1, dp1, dn1, tk1} !== {24'h000002, 3'b101}) begin
            errors++; $display("FAIL reload got t=%h pulse=%b done=%b tick=%b want 000002 1 0 1", t1, dp1, dn1, tk1);
        end
        checks++;
        if ({t0, dn0} !== {24'h000000, 1'b1}) begin
            errors++; $display("FAIL plain_expire got %h/%b want 000000/1", t0, dn0);
        end
        step(); step();
        reset = 1'b1;
        step();
        checks++;
        if ({t1, tk1, rn1, dn1, dp1, er1, t0, tk0, rn0, dn0, dp0, er0} !== 58'd0) begin
            errors++; $display("FAIL mid_reset got %h/%h want 0/0", {t1, tk1, rn1, dn1, dp1, er1}, {t0, tk0, rn0, dn0, dp0, er0});
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            load = 1'b0;
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            else reset = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                load = 1'b1;
                case ($urandom_range(0, 3))
                    0, 1:    set_time = sec2bcd($urandom_range(0, 6));
                    2:       set_time = sec2bcd(HL * 3600 - $urandom_range(1, 3));
                    default: set_time = 24'($urandom);
                endcase
            end
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 40) == 0 && (m_secs[0] / 3600) < HL && (m_secs[1] / 3600) < HL)
                mode = ~mode;
            step();
            checks++;
            if ({t0, tk0, rn0, dn0, dp0, er0} !== {sec2bcd(m_secs[0]), m_tick[0], m_run[0], m_done[0], m_dp[0], m_err[0]}) begin
                errors++;
                $display("FAIL rand_dut0 cyc %0d got %h want %h", c, {t0, tk0, rn0, dn0, dp0, er0},
                         {sec2bcd(m_secs[0]), m_tick[0], m_run[0], m_done[0], m_dp[0], m_err[0]});
            end
            checks++;
            if ({t1, tk1, rn1, dn1, dp1, er1} !== {sec2bcd(m_secs[1]), m_tick[1], m_run[1], m_done[1], m_dp[1], m_err[1]}) begin
                errors++;
                $display("FAIL rand_dut1 cyc %0d got %h want %h", c, {t1, tk1, rn1, dn1, dp1, er1},
                         {sec2bcd(m_secs[1]), m_tick[1], m_run[1], m_done[1], m_dp[1], m_err[1]});
            end
        end
        load  = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_secs[k] = 0; m_rel[k] = 0; m_pre[k] = 0; m_done[k] = 0;
            m_tick[k] = 0; m_dp[k] = 0; m_err[k] = 0; m_run[k] = 0;
        end
        #2;
        test_reset();
        test_countdown();
        test_borrow();
        test_up_wrap();
        test_validation();
        test_pause();
        test_auto_reload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nap_countdown_core.md
Name: nap_countdown_core

Overview:
Parametrised successor to the fixed HH:MM:SS BCD countdown register. Holds six BCD digits and counts down (nap timer) or up (stopwatch/clock) on an internal one-second enable. Adds pause/resume, input validation, optional auto-reload and an up-mode hour wrap. Replaces the divided-clock scheme with a single-clock prescaler enable; sits between the keypad/setting logic and the 7-segment display/alarm drivers.

Parameters:
TICK_DIV, 1000000, clock cycles per one-second tick (>=2)
HOUR_LIMIT, 24, up-mode hour wrap value (1..100); 100 means wrap after 99:59:59
AUTO_RELOAD, 0, 1 = down-mode expiry reloads the last valid loaded value instead of stopping

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle strobe: capture set_time
set_time  in  24  BCD {h10,h1,m10,m1,s10,s1}, 4 bits each, h10 in MSBs
run  in  1  level: 1 = count, 0 = pause
mode  in  1  0 = count down, 1 = count up
time_out  out  24  current BCD time, same packing as set_time
tick  out  1  one-cycle pulse when a second is applied
running  out  1  run & ~done (registered)
done  out  1  level: down-mode expiry, held until load or reset
done_pulse  out  1  one-cycle pulse on expiry (down) or wrap (up)
set_err  out  1  one-cycle pulse: load rejected

Behaviour:
- One clock; reset is synchronous and active-high. On a reset edge: time_out=0, prescaler=0, reload copy=0, all flags 0.
- Prescaler: counts 0..TICK_DIV-1 while run=1 and done=0. Its terminal count produces an internal tick that is applied at that same edge. It then wraps to 0. run=0 freezes the count (pause keeps the partial second). load clears it to 0.
- Priority per edge: reset > load > tick.
- Load validation: s1,m1,h1<=9; s10,m10<=5; h10<=9. In up mode, hours must also be < HOUR_LIMIT.
  - Valid: time_out=set_time at the next edge, reload copy updated, done cleared.
  - Invalid: time_out and reload copy unchanged, set_err=1 for exactly one cycle, done unchanged.
- Down tick:
  - BCD decrement with borrows s1->s10 (0->5), m1->m10 (0->5), h1->h10.
  - When the result is 00:00:00, or on a tick while already at 00:00:00: done=1 and done_pulse=1 at the same edge, and counting halts.
  - If AUTO_RELOAD=1: time_out is loaded with the reload copy instead, done stays 0, done_pulse=1, and counting continues. A reload copy of zero behaves as if AUTO_RELOAD=0.
- Up tick:
  - BCD increment with carries.
  - At HOUR_LIMIT-1:59:59 the next tick gives 00:00:00 with done_pulse=1. done is not set.
- tick pulses on every edge where a tick is applied, in either mode.
- mode changes apply from the next tick; the prescaler is not disturbed. If done=1, counting stays halted in either mode until load.
- load and tick in the same cycle: load wins and the tick is discarded.
- Reset mid-count: all state is cleared at that edge; no pulses are emitted.
- Latency: load->time_out is 1 cycle. Terminal prescaler count->time_out/tick/done is 0 extra cycles, because all outputs are registered at the same edge.

Decomposition:
- Package nap_timer_pkg:
  - bcd_t (4-bit) type
  - TIME_W=24 constant
  - digit index constants H10..S1
  - digit limit constants (9, 5)
  - functions bcd_time_valid, bcd_time_dec, bcd_time_inc, bcd_time_is_zero
- Sub-module tick_prescaler (TICK_DIV; inputs clock, reset, en, clr; output tick) replaces the clock-divider primitive.

Test Plan:
All scenarios use TICK_DIV=4.
1. Load 00:00:03, mode=0, run=1 -> time_out reads 02, 01, 00 at 4-clock spacing. done and done_pulse rise on the third tick; done_pulse lasts 1 cycle; running=0; time_out then holds.
2. Load 01:00:00, down, one tick -> 00:59:59. Load 10:00:00, one tick -> 09:59:59.
3. HOUR_LIMIT=24, load 23:59:59, mode=1, one tick -> 00:00:00, done_pulse=1, done=0, counting continues to 00:00:01.
4. Load 00:60:00 -> set_err one cycle, time_out unchanged. Load 24:00:00 in up mode -> rejected. Load 24:00:00 in down mode -> accepted.
5. Pause: drop run after 2 cycles of a second, hold 10 cycles, restore -> tick fires 2 cycles after resume. load asserted on a terminal count -> loaded value shown, no decrement.
6. AUTO_RELOAD=1, load 00:00:02, down -> 01, then reload to 00:00:02 with done_pulse, done=0. Assert reset mid-count -> all outputs 0 at the next edge.
